// File: rtl/adder_pkg.sv
// Shared types and helpers for the pipelined adder: operation encoding,
// carry-in / operand-inversion selection and a geometry check for the slicing.
package adder_pkg;

  typedef enum logic [1:0] {
    ADD  = 2'd0,
    SUB  = 2'd1,
    ADDC = 2'd2,
    SUBB = 2'd3
  } op_e;

  // Subtraction is done as a + ~b + c0, so B is inverted for both SUB flavours.
  function automatic logic op_is_sub(op_e op);
    return (op == SUB) || (op == SUBB);
  endfunction

  // Borrow-in for SUBB is the complement of the carry-in into the adder.
  function automatic logic carry_in(op_e op, logic cin);
    logic c0;
    unique case (op)
      ADD:     c0 = 1'b0;
      SUB:     c0 = 1'b1;
      ADDC:    c0 = cin;
      SUBB:    c0 = ~cin;
      default: c0 = 1'b0;
    endcase
    return c0;
  endfunction

  function automatic bit geometry_ok(int width, int stages);
    return (stages >= 1) && (width >= stages) && (width % stages == 0);
  endfunction

endpackage

// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle of the pipelined adder. The adder is the
// slave; whoever feeds operands and drains results uses the master side.
interface pipelined_adder_if #(
  parameter int WIDTH = 8
);
  logic                in_valid_test;
  logic                in_ready_test;
  logic [WIDTH-1:0]    a_test;
  logic [WIDTH-1:0]    b_test;
  adder_pkg::op_e      op_test;
  logic                cin_test;
  logic                out_valid_test;
  logic                out_ready_test;
  logic [WIDTH-1:0]    sum_test;
  logic                carry_test;
  logic                ovf_test;

  modport slave (
    input  in_valid_test, a_test, b_test, op_test, cin_test, out_ready_test,
    output in_ready_test, out_valid_test, sum_test, carry_test, ovf_test
  );

  modport master (
    output in_valid_test, a_test, b_test, op_test, cin_test, out_ready_test,
    input  in_ready_test, out_valid_test, sum_test, carry_test, ovf_test
  );
endinterface

// File: rtl/adder_slice.sv
// One pipeline stage: adds the low SW bits of the pending operands, then
// rotates the partial result word so the next stage again works on the low bits.
module adder_slice #(
  parameter int WIDTH = 8,
  parameter int SW    = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_valid,
  output logic             up_ready,
  input  logic [WIDTH-1:0] up_x,
  input  logic [WIDTH-1:0] up_y,
  input  logic             up_c,
  input  logic [1:0]       up_msb,
  output logic             dn_valid,
  input  logic             dn_ready,
  output logic [WIDTH-1:0] dn_x,
  output logic [WIDTH-1:0] dn_y,
  output logic             dn_c,
  output logic [1:0]       dn_msb
);

  logic [SW:0]      slice_sum;
  logic [WIDTH-1:0] x_next;
  logic [WIDTH-1:0] y_next;

  // An empty stage takes a beat even while downstream stalls.
  assign up_ready  = !dn_valid || dn_ready;
  assign slice_sum = {1'b0, up_x[SW-1:0]} + {1'b0, up_y[SW-1:0]} + {{SW{1'b0}}, up_c};

  // x carries finished slices in its top bits and unprocessed A slices below;
  // after STAGES rotations the finished slices sit in natural order.
  if (SW == WIDTH) begin : g_single
    assign x_next = slice_sum[SW-1:0];
    assign y_next = '0;
  end else begin : g_multi
    assign x_next = {slice_sum[SW-1:0], up_x[WIDTH-1:SW]};
    assign y_next = {{SW{1'b0}}, up_y[WIDTH-1:SW]};
  end

  // NOTE: non-blocking assignments so every stage samples its upstream's
  // pre-edge value; blocking here would let a beat race through several stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dn_valid <= 1'b0;
      // NOTE: data registers are reset as well, not only the valid bit, so the
      // result outputs read 0 coming out of reset.
      dn_x     <= '0;
      dn_y     <= '0;
      dn_c     <= 1'b0;
      dn_msb   <= '0;
    end else if (up_ready) begin
      dn_valid <= up_valid;
      if (up_valid) begin
        dn_x   <= x_next;
        dn_y   <= y_next;
        dn_c   <= slice_sum[SW];
        dn_msb <= up_msb;
      end
    end
  end

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit add/subtract split into STAGES carry-chain slices, one register per
// slice, with a valid/ready handshake whose bubbles collapse stage by stage.
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input logic              clk_test,
  input logic              rst_n_test,
  pipelined_adder_if.slave bus
);

  localparam int SW = WIDTH / STAGES;

  if (!geometry_ok(WIDTH, STAGES)) begin : g_bad_geometry
    $error("pipelined_adder: WIDTH must be a non-zero multiple of STAGES");
  end

  // Index k is the input side of stage k; index STAGES is the output register.
  logic             valid [0:STAGES];
  logic             ready [0:STAGES];
  logic [WIDTH-1:0] x     [0:STAGES];
  logic [WIDTH-1:0] y     [0:STAGES];
  logic             c     [0:STAGES];
  logic [1:0]       msb   [0:STAGES];

  assign valid[0] = bus.in_valid_test;
  assign x[0]     = bus.a_test;
  assign y[0]     = bus.b_test ^ {WIDTH{op_is_sub(bus.op_test)}};
  assign c[0]     = carry_in(bus.op_test, bus.cin_test);
  // Operand sign bits travel alongside because x is overwritten slice by slice.
  assign msb[0]   = {bus.a_test[WIDTH-1], y[0][WIDTH-1]};

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    adder_slice #(
      .WIDTH (WIDTH),
      .SW    (SW)
    ) u_slice (
      .clk      (clk_test),
      .rst_n    (rst_n_test),
      .up_valid (valid[k]),
      .up_ready (ready[k]),
      .up_x     (x[k]),
      .up_y     (y[k]),
      .up_c     (c[k]),
      .up_msb   (msb[k]),
      .dn_valid (valid[k+1]),
      .dn_ready (ready[k+1]),
      .dn_x     (x[k+1]),
      .dn_y     (y[k+1]),
      .dn_c     (c[k+1]),
      .dn_msb   (msb[k+1])
    );
  end

  assign ready[STAGES]      = bus.out_ready_test;
  assign bus.in_ready_test  = ready[0];
  assign bus.out_valid_test = valid[STAGES];
  assign bus.sum_test       = x[STAGES];
  assign bus.carry_test     = c[STAGES];
  // Same-sign operands producing an opposite-sign result is signed overflow.
  assign bus.ovf_test       = (msb[STAGES][1] == msb[STAGES][0]) &&
                              (x[STAGES][WIDTH-1] != msb[STAGES][1]);

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: directed vectors and handshake corner cases on an
// 8/2 instance, then random traffic on 16/1 and 32/4 against a plain-arithmetic model.
module tb_pipelined_adder;
  import adder_pkg::*;

  typedef struct packed {
    logic        ovf;
    logic        carry;
    logic [31:0] sum;
  } res_t;

  typedef struct {
    op_e        op;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] sum;
    logic       carry;
    logic       ovf;
  } vec_t;

  localparam int N_BEATS = 10000;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipelined_adder_if #(.WIDTH(8))  bus8 ();
  pipelined_adder_if #(.WIDTH(16)) bus16 ();
  pipelined_adder_if #(.WIDTH(32)) bus32 ();

  pipelined_adder #(.WIDTH(8),  .STAGES(2)) u_add8  (.clk_test(clk), .rst_n_test(rst_n), .bus(bus8));
  pipelined_adder #(.WIDTH(16), .STAGES(1)) u_add16 (.clk_test(clk), .rst_n_test(rst_n), .bus(bus16));
  pipelined_adder #(.WIDTH(32), .STAGES(4)) u_add32 (.clk_test(clk), .rst_n_test(rst_n), .bus(bus32));

  int n_tests = 0;
  int n_fail  = 0;

  res_t q16[$];
  res_t q32[$];

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Reference: integer arithmetic on the operands, carry = unsigned carry or
  // "no borrow", overflow = true signed result outside the w-bit range.
  function automatic res_t ref_calc(int w, op_e op, logic [31:0] a, logic [31:0] b, logic cin);
    longint m    = (longint'(1) << w) - 1;
    longint half = longint'(1) << (w - 1);
    longint ua   = longint'(a) & m;
    longint ub   = longint'(b) & m;
    longint sa   = (ua >= half) ? ua - (m + 1) : ua;
    longint sb   = (ub >= half) ? ub - (m + 1) : ub;
    longint ci   = (op == ADDC || op == SUBB) ? longint'(cin) : 0;
    longint full;
    longint sres;
    res_t   r;
    if (op == SUB || op == SUBB) begin
      full    = ua - ub - ci;
      sres    = sa - sb - ci;
      r.carry = (full >= 0);
    end else begin
      full    = ua + ub + ci;
      sres    = sa + sb + ci;
      r.carry = (full > m);
    end
    r.sum = 32'(full & m);
    r.ovf = (sres >= half) || (sres < -half);
    return r;
  endfunction

  task automatic idle_all();
    bus8.in_valid_test   = 1'b0;
    bus8.out_ready_test  = 1'b1;
    bus16.in_valid_test  = 1'b0;
    bus16.out_ready_test = 1'b1;
    bus32.in_valid_test  = 1'b0;
    bus32.out_ready_test = 1'b1;
  endtask

  // Single beat on the 8/2 instance: result must appear two edges after accept.
  task automatic run_vec(int idx, vec_t v);
    int lat;
    @(negedge clk);
    bus8.op_test        = v.op;
    bus8.a_test         = v.a;
    bus8.b_test         = v.b;
    bus8.cin_test       = v.cin;
    bus8.out_ready_test = 1'b1;
    bus8.in_valid_test  = 1'b1;
    @(negedge clk);
    bus8.in_valid_test = 1'b0;
    lat = 1;
    #1;
    while (!bus8.out_valid_test && lat < 10) begin
      @(negedge clk);
      #1;
      lat++;
    end
    check($sformatf("vec%0d_latency", idx), lat, 2);
    check($sformatf("vec%0d_result", idx),
          {bus8.ovf_test, bus8.carry_test, bus8.sum_test},
          {v.ovf, v.carry, v.sum});
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[12];
    int   i;
    int   k;
    int   extra;
    int   sent16, sent32, got16, got32, cyc;
    res_t exp_r;

    vecs[0]  = '{ADD,  8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[1]  = '{SUB,  8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0};
    vecs[2]  = '{SUB,  8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1};
    vecs[3]  = '{ADD,  8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    vecs[4]  = '{ADDC, 8'h0F, 8'h00, 1'b1, 8'h10, 1'b0, 1'b0};
    vecs[5]  = '{SUBB, 8'h10, 8'h05, 1'b1, 8'h0A, 1'b1, 1'b0};
    vecs[6]  = '{ADD,  8'h01, 8'h01, 1'b1, 8'h02, 1'b0, 1'b0};
    vecs[7]  = '{SUB,  8'h03, 8'h03, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[8]  = '{SUBB, 8'h00, 8'h00, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[9]  = '{ADDC, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
    vecs[10] = '{ADDC, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
    vecs[11] = '{SUBB, 8'h7F, 8'hFF, 1'b1, 8'h7F, 1'b0, 1'b0};

    idle_all();
    bus8.op_test  = ADD;  bus8.a_test  = '0; bus8.b_test  = '0; bus8.cin_test  = 1'b0;
    bus16.op_test = ADD;  bus16.a_test = '0; bus16.b_test = '0; bus16.cin_test = 1'b0;
    bus32.op_test = ADD;  bus32.a_test = '0; bus32.b_test = '0; bus32.cin_test = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_out_valid", bus8.out_valid_test, 0);
    rst_n = 1'b1;
    #1;
    check("reset_in_ready", bus8.in_ready_test, 1);

    for (int v = 0; v < 12; v++) run_vec(v, vecs[v]);

    // Backpressure: four back-to-back beats with out_ready held low three cycles
    bus8.op_test  = ADD;
    bus8.cin_test = 1'b0;
    i = 0;
    k = 0;
    for (int c = 0; c < 40 && k < 4; c++) begin
      @(negedge clk);
      bus8.out_ready_test = (c >= 3);
      bus8.in_valid_test  = (i < 4);
      bus8.a_test         = 8'(i + 1);
      bus8.b_test         = 8'(i + 1);
      #1;
      if (c == 2) check("bp_full_in_ready", bus8.in_ready_test, 0);
      if (c == 3) check("bp_push_pop_in_ready", bus8.in_ready_test, 1);
      if (bus8.out_valid_test && bus8.out_ready_test) begin
        check($sformatf("bp_out%0d", k), bus8.sum_test, 8'(2 * (k + 1)));
        k++;
      end
      if (bus8.in_valid_test && bus8.in_ready_test) i++;
    end
    check("bp_count", k, 4);
    bus8.in_valid_test = 1'b0;
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      #1;
      if (bus8.out_valid_test) extra++;
    end
    check("bp_no_duplicate", extra, 0);

    // Reset with two beats in flight
    @(negedge clk);
    bus8.out_ready_test = 1'b0;
    bus8.in_valid_test  = 1'b1;
    bus8.a_test         = 8'h10;
    bus8.b_test         = 8'h10;
    @(negedge clk);
    bus8.a_test = 8'h20;
    @(negedge clk);
    bus8.in_valid_test = 1'b0;
    #1;
    check("rst_pre_out_valid", bus8.out_valid_test, 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_out_valid", bus8.out_valid_test, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus8.out_ready_test = 1'b1;
    #1;
    check("rst_in_ready", bus8.in_ready_test, 1);
    extra = 0;
    repeat (6) begin
      @(negedge clk);
      #1;
      if (bus8.out_valid_test) extra++;
    end
    check("rst_no_stale", extra, 0);

    // Random traffic on 16/1 and 32/4 with random backpressure
    sent16 = 0; sent32 = 0; got16 = 0; got32 = 0; cyc = 0;
    while ((got16 < N_BEATS || got32 < N_BEATS) && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      bus16.out_ready_test = ($urandom_range(3) != 0);
      bus16.in_valid_test  = (sent16 < N_BEATS) && ($urandom_range(4) != 0);
      bus16.op_test        = op_e'($urandom_range(3));
      bus16.a_test         = ($urandom_range(7) == 0) ? 16'hFFFF : 16'($urandom);
      bus16.b_test         = 16'($urandom);
      bus16.cin_test       = 1'($urandom);
      bus32.out_ready_test = ($urandom_range(3) != 0);
      bus32.in_valid_test  = (sent32 < N_BEATS) && ($urandom_range(4) != 0);
      bus32.op_test        = op_e'($urandom_range(3));
      bus32.a_test         = ($urandom_range(7) == 0) ? 32'h8000_0000 : $urandom;
      bus32.b_test         = ($urandom_range(7) == 0) ? 32'hFFFF_FFFF : $urandom;
      bus32.cin_test       = 1'($urandom);
      #1;
      if (bus16.out_valid_test && bus16.out_ready_test) begin
        if (q16.size() == 0) check("rnd16_underflow", q16.size(), 1);
        else begin
          exp_r = q16.pop_front();
          check("rnd16_beat", {bus16.ovf_test, bus16.carry_test, 16'h0, bus16.sum_test}, exp_r);
          got16++;
        end
      end
      if (bus16.in_valid_test && bus16.in_ready_test) begin
        q16.push_back(ref_calc(16, bus16.op_test, 32'(bus16.a_test), 32'(bus16.b_test), bus16.cin_test));
        sent16++;
      end
      if (bus32.out_valid_test && bus32.out_ready_test) begin
        if (q32.size() == 0) check("rnd32_underflow", q32.size(), 1);
        else begin
          exp_r = q32.pop_front();
          check("rnd32_beat", {bus32.ovf_test, bus32.carry_test, bus32.sum_test}, exp_r);
          got32++;
        end
      end
      if (bus32.in_valid_test && bus32.in_ready_test) begin
        q32.push_back(ref_calc(32, bus32.op_test, bus32.a_test, bus32.b_test, bus32.cin_test));
        sent32++;
      end
    end
    check("rnd16_count", got16, N_BEATS);
    check("rnd32_count", got32, N_BEATS);

    idle_all();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
